// File: rtl/chroma_sub422.sv
// ---------------------------------------------------------------------------
// chroma_sub422
//
// Purpose:
//   Converts a 4:4:4 YCbCr pixel stream into 4:2:2 pixel pairs. Each pair
//   carries the luma of both pixels and the rounded average of their chroma.
//   A small line/frame position tracker flags the last pair of every line
//   and of every frame so the downstream stage can frame its blocks.
//
// Parameters:
//   LINE_W    - pixels per line (even, >= 2)
//   NUM_LINES - lines per frame (>= 1)
//
// Ports:
//   clk         in   single clock, all logic on its rising edge
//   rst         in   synchronous active-high reset
//   y_i         in   [7:0] luma of the incoming pixel
//   cb_i        in   [7:0] blue-difference chroma of the incoming pixel
//   cr_i        in   [7:0] red-difference chroma of the incoming pixel
//   vld_i       in   incoming pixel valid (no backpressure)
//   y0_o        out  [7:0] luma of the even pixel of the pair
//   y1_o        out  [7:0] luma of the odd pixel of the pair
//   cb_o        out  [7:0] averaged Cb of the pair
//   cr_o        out  [7:0] averaged Cr of the pair
//   vld_o       out  one-cycle pulse per produced pair
//   eol_o       out  high with vld_o on the last pair of a line
//   eof_o       out  high with vld_o on the last pair of a frame
//
// Build option:
//   CHROMA_LEVEL_SHIFT_EN - when defined, the four data outputs are presented
//   as two's-complement values offset by -128 (MSB inverted) for a DCT stage.
//   Timing is identical with and without the macro.
// ---------------------------------------------------------------------------
module chroma_sub422 #(
  parameter int LINE_W    = 640,
  parameter int NUM_LINES = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] y_i,
  input  logic [7:0] cb_i,
  input  logic [7:0] cr_i,
  input  logic       vld_i,
  output logic [7:0] y0_o,
  output logic [7:0] y1_o,
  output logic [7:0] cb_o,
  output logic [7:0] cr_o,
  output logic       vld_o,
  output logic       eol_o,
  output logic       eof_o
);

  // Counter widths; a one-entry range still needs one bit of storage.
  localparam int XW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  localparam logic [XW-1:0] X_LAST    = XW'(LINE_W - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(NUM_LINES - 1);

  // Inverting the MSB of an unsigned 8-bit value is the same as subtracting
  // 128 and reinterpreting as two's complement.
`ifdef CHROMA_LEVEL_SHIFT_EN
  localparam logic [7:0] OUT_XOR = 8'h80;
`else
  localparam logic [7:0] OUT_XOR = 8'h00;
`endif

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [7:0]      y_hold;
  logic [7:0]      cb_hold;
  logic [7:0]      cr_hold;

  logic [XW-1:0]   x_cnt;
  logic [LW-1:0]   line_cnt;

  logic            pair_fire;
  logic            hold_load;
  logic            x_last;
  logic            line_last;
  logic [8:0]      cb_sum;
  logic [8:0]      cr_sum;
  logic [7:0]      cb_avg;
  logic [7:0]      cr_avg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EVEN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control. Idle cycles leave everything in place,
  // so gaps of any length between the two pixels of a pair are harmless.
  always_comb begin
    state_next = state;
    pair_fire  = 1'b0;
    hold_load  = 1'b0;
    unique case (state)
      EVEN: begin
        if (vld_i) begin
          hold_load  = 1'b1;
          state_next = ODD;
        end
      end
      ODD: begin
        if (vld_i) begin
          pair_fire  = 1'b1;
          state_next = EVEN;
        end
      end
      default: begin
        state_next = EVEN;
      end
    endcase
  end

  // Rounded chroma average. The 9-bit sum holds up to 255+255+1 = 511, so
  // taking bits [8:1] can never exceed 255.
  always_comb begin
    cb_sum = {1'b0, cb_hold} + {1'b0, cb_i} + 9'd1;
    cr_sum = {1'b0, cr_hold} + {1'b0, cr_i} + 9'd1;
    cb_avg = cb_sum[8:1];
    cr_avg = cr_sum[8:1];
  end

  // Position flags for the pixel currently on the input.
  always_comb begin
    x_last    = (x_cnt == X_LAST);
    line_last = (line_cnt == LINE_LAST);
  end

  // Even-pixel hold registers. A pixel held here when reset arrives is
  // simply lost; it never reaches the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_hold  <= 8'd0;
      cb_hold <= 8'd0;
      cr_hold <= 8'd0;
    end else if (hold_load) begin
      y_hold  <= y_i;
      cb_hold <= cb_i;
      cr_hold <= cr_i;
    end
  end

  // Pixel and line position. Because LINE_W is even the FSM is always back
  // in EVEN when x wraps, so a pair never straddles two lines, and the next
  // frame begins on the very next accepted pixel after the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt    <= '0;
      line_cnt <= '0;
    end else if (vld_i) begin
      if (x_last) begin
        x_cnt <= '0;
        if (line_last) begin
          line_cnt <= '0;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Output register. Every cycle without a fresh pair clears all outputs,
  // so vld_o/eol_o/eof_o are single-cycle pulses and data reads as zero
  // between pairs.
  always_ff @(posedge clk) begin
    if (rst) begin
      y0_o  <= 8'd0;
      y1_o  <= 8'd0;
      cb_o  <= 8'd0;
      cr_o  <= 8'd0;
      vld_o <= 1'b0;
      eol_o <= 1'b0;
      eof_o <= 1'b0;
    end else if (pair_fire) begin
      y0_o  <= y_hold ^ OUT_XOR;
      y1_o  <= y_i ^ OUT_XOR;
      cb_o  <= cb_avg ^ OUT_XOR;
      cr_o  <= cr_avg ^ OUT_XOR;
      vld_o <= 1'b1;
      eol_o <= x_last;
      eof_o <= x_last & line_last;
    end else begin
      y0_o  <= 8'd0;
      y1_o  <= 8'd0;
      cb_o  <= 8'd0;
      cr_o  <= 8'd0;
      vld_o <= 1'b0;
      eol_o <= 1'b0;
      eof_o <= 1'b0;
    end
  end

endmodule
